// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the single-cycle core.
// Assembles LE words, writes imem, verifies XOR checksum, gates core reset.
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        restart,
  output logic [31:0] LoadProg_addr,
  output logic [31:0] LoadProg_data,
  output logic        LoadProg_we,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] words_loaded
);

  localparam logic [31:0] MAXW = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_n;
  logic [1:0]  bcnt, bcnt_n;
  logic [23:0] sh, sh_n;
  logic [31:0] nwords, nwords_n;
  logic [10:0] k, k_n;
  logic [31:0] xsum, xsum_n;
  logic        pend, pend_n;
  logic [31:0] pend_word, pend_word_n;
  logic [31:0] pend_addr, pend_addr_n;
  logic        fin, fin_n;
  logic        fin_ok, fin_ok_n;
  logic        rdy_n;
  logic        acc, last, rs;
  logic [31:0] word;

  assign acc  = rx_valid && rx_ready && !restart;
  assign last = acc && (bcnt == 2'd3);
  assign word = {rx_data, sh};
  assign rs   = restart && (state != S_IDLE);

  assign busy = (state == S_HDR) ||
                (state == S_LOAD) ||
                (state == S_CSUM);
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign core_rst = (state != S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n     = state;
    bcnt_n      = bcnt;
    sh_n        = sh;
    nwords_n    = nwords;
    k_n         = k;
    xsum_n      = xsum;
    pend_n      = 1'b0;
    pend_word_n = pend_word;
    pend_addr_n = pend_addr;
    fin_n       = fin;
    fin_ok_n    = fin_ok;
    if (acc) begin
      bcnt_n = bcnt + 2'd1;
      sh_n   = {rx_data, sh[23:8]};
    end
    unique case (state)
      S_IDLE: state_n = S_HDR;
      S_HDR: begin
        if (last) begin
          nwords_n = word;
          if (word == 32'd0 || word > MAXW)
            state_n = S_ERR;
          else
            state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        if (last) begin
          pend_n      = 1'b1;
          pend_word_n = word;
          pend_addr_n = BASE_ADDR +
                        {19'd0, k, 2'b00};
          k_n         = k + 11'd1;
          xsum_n      = xsum ^ word;
          if ({21'd0, k} + 32'd1 == nwords)
            state_n = S_CSUM;
        end
      end
      S_CSUM: begin
        // compare is registered; ready drops meanwhile
        if (fin) begin
          state_n = fin_ok ? S_DONE : S_ERR;
          fin_n   = 1'b0;
        end else if (last) begin
          fin_n    = 1'b1;
          fin_ok_n = (word == xsum);
        end
      end
      default: ;
    endcase
    if (rs) begin
      state_n  = S_HDR;
      bcnt_n   = 2'd0;
      sh_n     = 24'd0;
      nwords_n = 32'd0;
      k_n      = 11'd0;
      xsum_n   = 32'd0;
      pend_n   = 1'b0;
      fin_n    = 1'b0;
    end
    rdy_n = (state != S_IDLE) && !fin_n &&
            ((state_n == S_HDR) ||
             (state_n == S_LOAD) ||
             (state_n == S_CSUM));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt          <= 2'd0;
      sh            <= 24'd0;
      nwords        <= 32'd0;
      k             <= 11'd0;
      xsum          <= 32'd0;
      pend          <= 1'b0;
      pend_word     <= 32'd0;
      pend_addr     <= 32'd0;
      fin           <= 1'b0;
      fin_ok        <= 1'b0;
      rx_ready      <= 1'b0;
      LoadProg_we   <= 1'b0;
      LoadProg_addr <= 32'd0;
      LoadProg_data <= 32'd0;
      words_loaded  <= 11'd0;
    end else begin
      bcnt        <= bcnt_n;
      sh          <= sh_n;
      nwords      <= nwords_n;
      k           <= k_n;
      xsum        <= xsum_n;
      pend        <= pend_n;
      pend_word   <= pend_word_n;
      pend_addr   <= pend_addr_n;
      fin         <= fin_n;
      fin_ok      <= fin_ok_n;
      rx_ready    <= rdy_n;
      LoadProg_we <= pend && !rs;
      if (pend && !rs) begin
        LoadProg_addr <= pend_addr;
        LoadProg_data <= pend_word;
      end
      if (rs)
        words_loaded <= 11'd0;
      else if (pend)
        words_loaded <= words_loaded + 11'd1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized byte streams checked against a
// stream-level model of the loader (writes, result, timing).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        restart = 1'b0;
  logic [31:0] LoadProg_addr;
  logic [31:0] LoadProg_data;
  logic        LoadProg_we;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [10:0] words_loaded;

  prog_loader dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .restart(restart),
    .LoadProg_addr(LoadProg_addr),
    .LoadProg_data(LoadProg_data),
    .LoadProg_we(LoadProg_we),
    .core_rst(core_rst),
    .busy(busy),
    .done(done),
    .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int we_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    int          e;
    int          wl;
  } wr_t;

  wr_t        expq[$];
  wr_t        w;
  logic [7:0] stream[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // per-cycle compare against the model's expected write list
  always @(negedge clk) begin
    if (rst) begin
      chk("status_onehot",
          32'($countones({busy, done, err}) <= 1), 32'd1);
      chk("core_rst_rule", 32'(core_rst), 32'(!done));
      if (done || err)
        chk("rdy_when_halted", 32'(rx_ready), 32'd0);
      if (LoadProg_we) begin
        we_total++;
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write act=%h/%h exp=none",
                   LoadProg_addr, LoadProg_data);
        end else begin
          w = expq.pop_front();
          chk("wr_addr", LoadProg_addr, w.a);
          chk("wr_data", LoadProg_data, w.d);
          chk("wr_edge", 32'(cyc), 32'(w.e));
          chk("wr_count", 32'(words_loaded), 32'(w.wl));
        end
      end
    end
  end

  function automatic logic [31:0] getw(input int i);
    return {stream[4*i+3], stream[4*i+2],
            stream[4*i+1], stream[4*i]};
  endfunction

  // 1 = DONE expected, 2 = ERR expected
  function automatic int model_result(output int wl);
    logic [31:0] n;
    logic [31:0] x;
    n = getw(0);
    if (n == 0 || n > 1024) begin
      wl = 0;
      return 2;
    end
    wl = int'(n);
    x = 32'd0;
    for (int k = 0; k < int'(n); k++) x ^= getw(1 + k);
    return (x == getw(1 + int'(n))) ? 1 : 2;
  endfunction

  task automatic push_word(input logic [31:0] v);
    stream.push_back(v[7:0]);
    stream.push_back(v[15:8]);
    stream.push_back(v[23:16]);
    stream.push_back(v[31:24]);
  endtask

  task automatic send_stream(input int gap_pct, input int upto);
    logic [31:0] n;
    logic        hv;
    int          k;
    int          wt;
    n  = getw(0);
    hv = (n != 0) && (n <= 1024);
    for (int i = 0; i < upto; i++) begin
      @(negedge clk);
      if ($urandom_range(99) < gap_pct) begin
        rx_valid = 1'b0;
        repeat (1 + $urandom_range(2)) @(negedge clk);
      end
      rx_valid = 1'b1;
      rx_data  = stream[i];
      wt = 0;
      while (!rx_ready && wt < 64) begin
        @(negedge clk);
        wt++;
      end
      if (!rx_ready) begin
        total++;
        bad++;
        $display("FAIL rx_ready_timeout act=0 exp=1 byte=%0d", i);
        rx_valid = 1'b0;
        return;
      end
      if (hv && i >= 4 && i < 4 + 4 * int'(n) && i % 4 == 3) begin
        k = (i - 4) / 4;
        expq.push_back('{a: 32'(4 * k), d: getw(1 + k),
                         e: cyc + 2, wl: k + 1});
      end
      @(posedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic finish_chk(input int res, input int wl);
    chk("rdy_after_last", 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk("done", 32'(done), 32'(res == 1));
    chk("err", 32'(err), 32'(res == 2));
    chk("core_rst_end", 32'(core_rst), 32'(res != 1));
    chk("busy_end", 32'(busy), 32'd0);
    chk("rx_ready_end", 32'(rx_ready), 32'd0);
    chk("words_loaded", 32'(words_loaded), 32'(wl));
    chk("missing_writes", 32'(expq.size()), 32'd0);
  endtask

  task automatic run_full(input int gap_pct);
    int res;
    int wl;
    send_stream(gap_pct, stream.size());
    res = model_result(wl);
    finish_chk(res, wl);
  endtask

  task automatic pulse_restart(input logic junk);
    restart  = 1'b1;
    rx_valid = junk;
    rx_data  = 8'hAA;
    @(negedge clk);
    restart  = 1'b0;
    rx_valid = 1'b0;
    chk("rs_busy", 32'(busy), 32'd1);
    chk("rs_core_rst", 32'(core_rst), 32'd1);
    chk("rs_rx_ready", 32'(rx_ready), 32'd1);
    chk("rs_words", 32'(words_loaded), 32'd0);
  endtask

  task automatic nominal(input logic [7:0] lastb);
    stream.delete();
    push_word(32'd2);
    push_word(32'h0050_0093);
    push_word(32'h0010_0113);
    push_word({lastb, 24'h40_0180});
  endtask

  task automatic chk_reset_vals();
    chk("r_addr", LoadProg_addr, 32'd0);
    chk("r_data", LoadProg_data, 32'd0);
    chk("r_we", 32'(LoadProg_we), 32'd0);
    chk("r_core_rst", 32'(core_rst), 32'd1);
    chk("r_rx_ready", 32'(rx_ready), 32'd0);
    chk("r_status", {29'd0, busy, done, err}, 32'd0);
    chk("r_words", 32'(words_loaded), 32'd0);
  endtask

  int          we0;
  int          n;
  logic [31:0] x;
  logic [31:0] v;

  initial begin
    #12;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    chk("idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("hdr_busy", 32'(busy), 32'd1);
    chk("hdr_rdy_late", 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk("hdr_rdy", 32'(rx_ready), 32'd1);

    // nominal load, pins the model with literals
    nominal(8'h00);
    chk("model_w0", getw(1), 32'h0050_0093);
    chk("model_csum", getw(1) ^ getw(2), getw(3));
    we0 = we_total;
    run_full(0);
    chk("nom_pulses", 32'(we_total - we0), 32'd2);
    chk("nom_last_addr", LoadProg_addr, 32'h4);
    chk("nom_last_data", LoadProg_data, 32'h0010_0113);
    chk("nom_done", 32'(done), 32'd1);

    // bad checksum
    pulse_restart(1'b0);
    nominal(8'h01);
    we0 = we_total;
    run_full(0);
    chk("badck_pulses", 32'(we_total - we0), 32'd2);
    chk("badck_err", 32'(err), 32'd1);

    // bad headers
    pulse_restart(1'b0);
    stream.delete();
    push_word(32'd0);
    we0 = we_total;
    run_full(0);
    pulse_restart(1'b0);
    stream.delete();
    push_word(32'd1025);
    run_full(0);
    chk("badhdr_pulses", 32'(we_total - we0), 32'd0);

    // gapped nominal
    pulse_restart(1'b0);
    nominal(8'h00);
    run_full(50);
    chk("gap_done", 32'(done), 32'd1);

    // restart mid-LOAD with a byte offered during restart
    pulse_restart(1'b0);
    nominal(8'h00);
    send_stream(0, 10);
    pulse_restart(1'b1);
    stream.delete();
    push_word(32'd1);
    push_word(32'hDEAD_BEEF);
    push_word(32'hDEAD_BEEF);
    we0 = we_total;
    run_full(20);
    chk("rs_pulses", 32'(we_total - we0), 32'd1);
    chk("rs_data", LoadProg_data, 32'hDEAD_BEEF);
    chk("rs_addr", LoadProg_addr, 32'h0);

    // randomized loads
    for (int r = 0; r < 12; r++) begin
      pulse_restart(1'b0);
      stream.delete();
      n = 1 + $urandom_range(7);
      push_word(32'(n));
      x = 32'd0;
      for (int k = 0; k < n; k++) begin
        v = $urandom;
        x ^= v;
        push_word(v);
      end
      if ($urandom_range(99) < 30) x ^= 32'(1) << $urandom_range(31);
      push_word(x);
      run_full($urandom_range(60));
    end

    // largest legal image
    pulse_restart(1'b0);
    stream.delete();
    push_word(32'd1024);
    x = 32'd0;
    for (int k = 0; k < 1024; k++) begin
      v = $urandom;
      x ^= v;
      push_word(v);
    end
    push_word(x);
    run_full(0);

    // async reset mid-word
    pulse_restart(1'b0);
    nominal(8'h00);
    send_stream(0, 6);
    #2;
    rst = 1'b0;
    #1;
    expq.delete();
    chk_reset_vals();
    @(negedge clk);
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b1;
    chk("ar_idle", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ar_hdr", 32'(busy), 32'd1);
    chk("ar_rdy_late", 32'(rx_ready), 32'd0);
    @(negedge clk);
    chk("ar_rdy", 32'(rx_ready), 32'd1);
    run_full(0);
    chk("ar_done", 32'(done), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
